// File: rtl/march_mbist.sv
// rtl/march_mbist.sv - March C- memory built-in self-test controller
//
// Runs March C- over a single-port synchronous RAM with a 1-cycle read latency:
//   M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0)
// While busy the controller owns mem_addr/mem_din/mem_we; otherwise they are held at 0.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             begin a run (accepted in IDLE/DONE only)
//   busy, done        run in progress / run finished (done held until next accepted start)
//   fail, fail_count  sticky mismatch flag and saturating mismatch count for the current run
//   first_fail_addr   address of the first mismatch of the run
//   first_fail_elem   march element (1..5) of the first mismatch
//   err_valid         1-cycle strobe per mismatch, with err_addr/err_data
//   mem_addr, mem_din, mem_we  RAM request; mem_dout  RAM read data
module march_mbist #(
  parameter int DW           = 8,
  parameter int AW           = 5,
  parameter int CW           = 8,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [CW-1:0] fail_count,
  output logic [AW-1:0] first_fail_addr,
  output logic [2:0]    first_fail_elem,
  output logic          err_valid,
  output logic [AW-1:0] err_addr,
  output logic [DW-1:0] err_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRT,
    S_RD,
    S_CMP,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] ADDR_MAX = '1;

  state_t        state;
  logic [AW-1:0] addr;
  logic [2:0]    elem;

  logic [DW-1:0] exp_bg;
  logic          down;
  logic          last_addr;
  logic [2:0]    next_elem;
  logic [AW-1:0] next_start;
  logic          mismatch;

  always_comb begin
    exp_bg     = '0;
    down       = 1'b0;
    next_elem  = elem + 3'd1;
    next_start = '0;
    // M2 and M4 read the all-ones background; M3/M4 walk the address space downwards
    if (elem == 3'd2 || elem == 3'd4) exp_bg = '1;
    if (elem == 3'd3 || elem == 3'd4) down = 1'b1;
    last_addr = down ? (addr == '0) : (addr == ADDR_MAX);
    if (next_elem == 3'd3 || next_elem == 3'd4) next_start = ADDR_MAX;
    mismatch = (mem_dout != exp_bg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      addr            <= '0;
      elem            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      fail            <= 1'b0;
      fail_count      <= '0;
      first_fail_addr <= '0;
      first_fail_elem <= '0;
      err_valid       <= 1'b0;
      err_addr        <= '0;
      err_data        <= '0;
      mem_addr        <= '0;
      mem_din         <= '0;
      mem_we          <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state           <= S_WRT;
            elem            <= '0;
            addr            <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            fail            <= 1'b0;
            fail_count      <= '0;
            first_fail_addr <= '0;
            first_fail_elem <= '0;
            // first M0 write is presented in the very first busy cycle
            mem_we          <= 1'b1;
            mem_addr        <= '0;
            mem_din         <= '0;
          end
        end

        S_WRT: begin
          if (addr == ADDR_MAX) begin
            state    <= S_RD;
            elem     <= 3'd1;
            addr     <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
          end else begin
            addr     <= addr + 1'b1;
            mem_addr <= addr + 1'b1;
          end
        end

        // address is already on the bus; RAM data is available in CMP
        S_RD: state <= S_CMP;

        S_CMP: begin
          if (mismatch) begin
            err_valid <= 1'b1;
            err_addr  <= addr;
            err_data  <= mem_dout;
            fail      <= 1'b1;
            if (fail_count != {CW{1'b1}}) fail_count <= fail_count + 1'b1;
            if (!fail) begin
              first_fail_addr <= addr;
              first_fail_elem <= elem;
            end
          end
          if ((mismatch && STOP_ON_FAIL != 0) || (elem == 3'd5 && last_addr)) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
          end else if (elem == 3'd5) begin
            state    <= S_RD;
            addr     <= addr + 1'b1;
            mem_addr <= addr + 1'b1;
          end else begin
            // the inverse background is written even after a failed compare
            state   <= S_WR;
            mem_we  <= 1'b1;
            mem_din <= ~exp_bg;
          end
        end

        S_WR: begin
          state   <= S_RD;
          mem_we  <= 1'b0;
          mem_din <= '0;
          if (last_addr) begin
            elem     <= next_elem;
            addr     <= next_start;
            mem_addr <= next_start;
          end else if (down) begin
            addr     <= addr - 1'b1;
            mem_addr <= addr - 1'b1;
          end else begin
            addr     <= addr + 1'b1;
            mem_addr <= addr + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_march_mbist.sv
// tb/tb_march_mbist.sv - self-checking bench for march_mbist (DW=8, AW=3)
module tb_march_mbist;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] start, busy, done, fail, err_valid, mem_we;
  logic [7:0] fail_count [2];
  logic [2:0] first_fail_addr [2];
  logic [2:0] first_fail_elem [2];
  logic [2:0] err_addr [2];
  logic [7:0] err_data [2];
  logic [2:0] mem_addr [2];
  logic [7:0] mem_din [2];
  logic [7:0] mem_dout [2];

  always #5 clk = ~clk;

  march_mbist #(.DW(8), .AW(3), .CW(8), .STOP_ON_FAIL(0)) dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .fail(fail[0]), .fail_count(fail_count[0]), .first_fail_addr(first_fail_addr[0]),
    .first_fail_elem(first_fail_elem[0]), .err_valid(err_valid[0]), .err_addr(err_addr[0]),
    .err_data(err_data[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]),
    .mem_we(mem_we[0]), .mem_dout(mem_dout[0])
  );

  march_mbist #(.DW(8), .AW(3), .CW(8), .STOP_ON_FAIL(1)) dut_b (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .fail(fail[1]), .fail_count(fail_count[1]), .first_fail_addr(first_fail_addr[1]),
    .first_fail_elem(first_fail_elem[1]), .err_valid(err_valid[1]), .err_addr(err_addr[1]),
    .err_data(err_data[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]),
    .mem_we(mem_we[1]), .mem_dout(mem_dout[1])
  );

  // behavioural RAMs with per-bit stuck-at masks shared by both instances
  logic [7:0] ram [2][8];
  logic [7:0] sa1 [8];
  logic [7:0] sa0 [8];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_we[i]) ram[i][mem_addr[i]] <= (mem_din[i] | sa1[mem_addr[i]]) & ~sa0[mem_addr[i]];
      mem_dout[i] <= (ram[i][mem_addr[i]] | sa1[mem_addr[i]]) & ~sa0[mem_addr[i]];
    end
  end

  // bus trace {we, addr, din-if-write} per busy cycle and mismatch strobes {addr, data}
  int          sel = 0;
  logic [11:0] trace [$];
  logic [10:0] errq [$];
  int          tb_i, eb_i;

  always @(negedge clk) begin
    if (busy[sel]) trace.push_back({mem_we[sel], mem_addr[sel], mem_we[sel] ? mem_din[sel] : 8'h00});
    if (err_valid[sel]) errq.push_back({err_addr[sel], err_data[sel]});
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // reference: walks the march algorithm over an array-of-words memory
  logic [11:0] exp_trace [$];
  logic [13:0] exp_err [$];
  logic [7:0]  exp_mem [8];

  task automatic model_run(input bit stop);
    bit halt;
    int a;
    logic [7:0] bg, rd;
    exp_trace.delete();
    exp_err.delete();
    halt = 0;
    for (int k = 0; k < 8; k++) begin
      exp_trace.push_back({1'b1, 3'(k), 8'h00});
      exp_mem[k] = sa1[k] & ~sa0[k];
    end
    for (int e = 1; e <= 5; e++) begin
      for (int k = 0; k < 8; k++) begin
        if (halt) break;
        a  = (e == 3 || e == 4) ? 7 - k : k;
        bg = (e == 2 || e == 4) ? 8'hFF : 8'h00;
        rd = (exp_mem[a] | sa1[a]) & ~sa0[a];
        exp_trace.push_back({1'b0, 3'(a), 8'h00});
        exp_trace.push_back({1'b0, 3'(a), 8'h00});
        if (rd != bg) begin
          exp_err.push_back({3'(e), 3'(a), rd});
          if (stop) halt = 1;
        end
        if (!halt && e != 5) begin
          exp_trace.push_back({1'b1, 3'(a), ~bg});
          exp_mem[a] = (~bg | sa1[a]) & ~sa0[a];
        end
      end
    end
  endtask

  task automatic clear_faults();
    for (int k = 0; k < 8; k++) begin
      sa1[k] = 8'h00;
      sa0[k] = 8'h00;
    end
  endtask

  task automatic wait_done(input int s);
    int n;
    n = 0;
    while (done[s] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("run_completes", done[s], 1);
  endtask

  task automatic run(input int s);
    sel  = s;
    tb_i = trace.size();
    eb_i = errq.size();
    @(negedge clk);
    start[s] = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
    wait_done(s);
    @(negedge clk);
  endtask

  task automatic compare_model(input int s);
    int nt, ne, diff;
    nt = trace.size() - tb_i;
    ne = errq.size() - eb_i;
    check("busy_cycles", nt, exp_trace.size());
    diff = -1;
    for (int k = 0; k < nt && k < exp_trace.size(); k++)
      if (trace[tb_i+k] !== exp_trace[k]) begin diff = k; break; end
    check("bus_trace_first_diff", diff, -1);
    check("err_strobes", ne, exp_err.size());
    diff = -1;
    for (int k = 0; k < ne && k < exp_err.size(); k++)
      if (errq[eb_i+k] !== exp_err[k][10:0]) begin diff = k; break; end
    check("err_strobe_first_diff", diff, -1);
    check("fail", fail[s], exp_err.size() != 0);
    check("fail_count", fail_count[s], exp_err.size() > 255 ? 255 : exp_err.size());
    check("first_fail_addr", first_fail_addr[s], exp_err.size() != 0 ? exp_err[0][10:8] : 3'd0);
    check("first_fail_elem", first_fail_elem[s], exp_err.size() != 0 ? exp_err[0][13:11] : 3'd0);
    diff = -1;
    for (int k = 0; k < 8; k++)
      if (ram[s][k] !== exp_mem[k]) begin diff = k; break; end
    check("final_ram_first_diff", diff, -1);
    check("idle_bus", {busy[s], mem_we[s], mem_addr[s], mem_din[s]}, 0);
  endtask

  function automatic logic [40:0] outs(input int i);
    return {busy[i], done[i], fail[i], fail_count[i], first_fail_addr[i], first_fail_elem[i],
            err_valid[i], err_addr[i], err_data[i], mem_addr[i], mem_din[i], mem_we[i]};
  endfunction

  typedef struct {
    bit         en;
    bit         sa_one;
    int         addr;
    int         bitn;
    bit         stop;
    bit         e_fail;
    int         e_cnt;
    int         e_faddr;
    int         e_felem;
    logic [7:0] e_data;
    int         e_cycles;
  } vec_t;

  vec_t tbl [7];
  int   idx_tab [8];
  logic [11:0] val_tab [8];

  initial begin
    int nw, nf, a, b, s;
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 120};
    tbl[1] = '{1, 1, 5, 0, 0, 1, 3, 5, 1, 8'h01, 120};
    tbl[2] = '{1, 1, 5, 0, 1, 1, 1, 5, 1, 8'h01, 25};
    tbl[3] = '{1, 0, 2, 7, 0, 1, 2, 2, 2, 8'h7F, 120};
    tbl[4] = '{1, 0, 2, 7, 1, 1, 1, 2, 2, 8'h7F, 40};
    tbl[5] = '{1, 1, 0, 3, 1, 1, 1, 0, 1, 8'h08, 10};
    tbl[6] = '{1, 0, 6, 1, 1, 1, 1, 6, 2, 8'hFD, 52};
    idx_tab = '{7, 10, 34, 56, 58, 59, 82, 106};
    val_tab = '{12'hF00, 12'h8FF, 12'h800, 12'h700, 12'hFFF, 12'h600, 12'hF00, 12'h100};

    rst = 1'b1;
    start = 2'b00;
    clear_faults();
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs_a", outs(0), 0);
    check("reset_outputs_b", outs(1), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      clear_faults();
      if (tbl[v].en) begin
        if (tbl[v].sa_one) sa1[tbl[v].addr] = 8'(1 << tbl[v].bitn);
        else sa0[tbl[v].addr] = 8'(1 << tbl[v].bitn);
      end
      s = tbl[v].stop ? 1 : 0;
      model_run(tbl[v].stop);
      run(s);
      check($sformatf("vec%0d_busy_cycles", v), trace.size() - tb_i, tbl[v].e_cycles);
      check($sformatf("vec%0d_fail", v), fail[s], tbl[v].e_fail);
      check($sformatf("vec%0d_fail_count", v), fail_count[s], tbl[v].e_cnt);
      check($sformatf("vec%0d_first_addr", v), first_fail_addr[s], tbl[v].e_faddr);
      check($sformatf("vec%0d_first_elem", v), first_fail_elem[s], tbl[v].e_felem);
      if (tbl[v].e_fail) check($sformatf("vec%0d_first_err_data", v),
                               errq.size() > eb_i ? errq[eb_i][7:0] : 8'hxx, tbl[v].e_data);
      compare_model(s);
      if (v == 0) begin
        for (int k = 0; k < 8; k++)
          check($sformatf("addr_order_idx%0d", idx_tab[k]), trace[tb_i+idx_tab[k]], val_tab[k]);
        for (int k = 0; k < 8; k++) check($sformatf("clean_ram%0d", k), ram[0][k], 8'h00);
      end
      if (v == 2) begin
        nw = 0;
        for (int k = 8; k < trace.size() - tb_i; k++)
          if (trace[tb_i+k][11] && trace[tb_i+k][10:8] > 3'd5) nw++;
        check("stop_no_writes_above_5", nw, 0);
      end
    end

    // start while busy is ignored
    clear_faults();
    model_run(0);
    sel = 0;
    tb_i = trace.size();
    eb_i = errq.size();
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (50) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    wait_done(0);
    @(negedge clk);
    compare_model(0);

    // start held high in DONE: results clear and runs restart back to back
    sa1[5] = 8'h01;
    run(0);
    check("held_pre_fail_count", fail_count[0], 3);
    start[0] = 1'b1;
    @(negedge clk);
    check("held_accept", {busy[0], done[0], fail[0], fail_count[0], first_fail_addr[0], first_fail_elem[0]},
          {1'b1, 1'b0, 1'b0, 8'd0, 3'd0, 3'd0});
    wait_done(0);
    @(negedge clk);
    check("held_reaccept", {busy[0], done[0]}, 2'b10);
    start[0] = 1'b0;
    wait_done(0);
    check("held_final_fail_count", fail_count[0], 3);
    @(negedge clk);

    // asynchronous reset mid-run, then a clean restart
    clear_faults();
    sel = 0;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (40) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("midrun_reset_outputs", outs(0), 0);
    check("midrun_reset_we", mem_we[0], 0);
    @(negedge clk);
    rst = 1'b0;
    model_run(0);
    run(0);
    compare_model(0);

    // randomized stuck-at faults against the reference
    for (int r = 0; r < 10; r++) begin
      clear_faults();
      nf = $urandom_range(0, 2);
      for (int f = 0; f < nf; f++) begin
        a = $urandom_range(0, 7);
        b = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1) sa1[a] = sa1[a] | 8'(1 << b);
        else sa0[a] = sa0[a] | 8'(1 << b);
        sa0[a] = sa0[a] & ~sa1[a];
      end
      s = $urandom_range(0, 1);
      model_run(s[0]);
      run(s);
      compare_model(s);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
